// File: rtl/unpooling_core_2x2_cxy_pkg.sv
// Shared definitions for the 2x2 nearest-neighbour unpooling core:
// default geometry, pooled-side sizes and the read-side FSM encoding.
package unpool_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_HEIGHT = 16;
  localparam int IN_W       = DEF_WIDTH / 2;
  localparam int IN_H       = DEF_HEIGHT / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROW_A = 2'd1,
    ROW_B = 2'd2
  } rd_state_t;

endpackage

// File: rtl/unpooling_core_2x2_cxy_if.sv
// Stream bundle for the unpooling core: pooled input side and upsampled
// output side, each with valid/ready. The core is the slave; the
// surrounding pipeline (or a bench) is the master.
interface unpooling_core_2x2_cxy_if #(
  parameter int DW = 24
);
  logic          DIN_VALID;
  logic [DW-1:0] DIN;
  logic          DIN_LAST_IN_LINE;
  logic          DIN_LAST_PIX;
  logic          DIN_READY;
  logic [DW-1:0] OUT;
  logic          VALID;
  logic          LAST_IN_LINE;
  logic          LAST_PIX;
  logic          OUT_READY;

  modport master (
    output DIN_VALID, DIN, DIN_LAST_IN_LINE, DIN_LAST_PIX, OUT_READY,
    input  DIN_READY, OUT, VALID, LAST_IN_LINE, LAST_PIX
  );

  modport slave (
    input  DIN_VALID, DIN, DIN_LAST_IN_LINE, DIN_LAST_PIX, OUT_READY,
    output DIN_READY, OUT, VALID, LAST_IN_LINE, LAST_PIX
  );
endinterface

// File: rtl/unpooling_core_2x2_cxy_line_bank.sv
// One pooled-line bank: synchronous write port, asynchronous read port and
// a full flag that the write side sets and the read side clears.
module unpool_line_bank #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 24
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          set_full,
  input  logic          clr_full,
  output logic          full
);

  logic [DW-1:0] mem [DEPTH];

  // Pixel storage write.
  // NOTE: the array has no reset; the full flag alone decides whether its contents are meaningful.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Full flag: set when the last pixel of a line lands, cleared when the line has been read out twice.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RSTn)         full <= 1'b0;
    else if (set_full) full <= 1'b1;
    else if (clr_full) full <= 1'b0;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/unpooling_core_2x2_cxy.sv
// 2x nearest-neighbour upsampler. Each pooled pixel becomes a 2x2 block:
// a pooled line is written into one of two ping-pong banks, then read out
// twice (ROW_A, ROW_B) with every pixel emitted on two consecutive columns.
// Optional build macro UNPOOL_PROTOCOL_CHECK_EN adds a sticky ERR output
// that flags DIN_LAST_IN_LINE / DIN_LAST_PIX disagreeing with the framing.
module unpooling_core_2x2_cxy
  import unpool_pkg::*;
#(
  parameter int P_WIDTH  = DEF_WIDTH,
  parameter int P_HEIGHT = DEF_HEIGHT,
  parameter int P_WCNT_W = 4,
  parameter int P_HCNT_W = 4,
  parameter int DW       = 24
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  unpooling_core_2x2_cxy_if.slave   bus
`ifdef UNPOOL_PROTOCOL_CHECK_EN
  ,
  output logic                      ERR
`endif
);

  localparam int AW = P_WCNT_W - 1;
  localparam logic [AW-1:0]       IN_COL_LAST  = AW'(P_WIDTH / 2 - 1);
  localparam logic [P_WCNT_W-1:0] OUT_COL_LAST = P_WCNT_W'(P_WIDTH - 1);
  localparam logic [P_HCNT_W-1:0] OUT_ROW_LAST = P_HCNT_W'(P_HEIGHT - 1);

  logic [1:0]          full;
  logic                wr_sel;
  logic                rd_sel;
  logic [AW-1:0]       in_col;
  logic [P_WCNT_W-1:0] out_col;
  logic [P_HCNT_W-1:0] out_row;
  logic [DW-1:0]       rdata [2];
  rd_state_t           state;
  rd_state_t           state_nxt;
  rd_state_t           row_eff;
  logic                accept;
  logic                in_line_end;
  logic                load;
  logic                out_line_end;
  logic                release_bank;

  assign bus.DIN_READY = ~full[wr_sel];
  assign accept        = bus.DIN_VALID & ~full[wr_sel];
  assign in_line_end   = accept & (in_col == IN_COL_LAST);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    unpool_line_bank #(
      .DEPTH (P_WIDTH / 2),
      .AW    (AW),
      .DW    (DW)
    ) u_bank (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .we       (accept & (wr_sel == 1'(b))),
      .waddr    (in_col),
      .wdata    (bus.DIN),
      .raddr    (out_col[P_WCNT_W-1:1]),
      .rdata    (rdata[b]),
      .set_full (in_line_end & (wr_sel == 1'(b))),
      .clr_full (release_bank & (rd_sel == 1'(b))),
      .full     (full[b])
    );
  end

  // Write side: column counter and bank pointer advance on every accepted pixel.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      in_col <= '0;
      wr_sel <= 1'b0;
    end else if (accept) begin
      in_col <= in_line_end ? '0 : in_col + 1'b1;
      if (in_line_end) wr_sel <= ~wr_sel;
    end
  end

  // Read FSM next state. IDLE with a full bank already behaves as ROW_A so the
  // first output pixel loads in the same cycle the full flag becomes visible.
  // A bank is released once its last ROW_B pixel is captured in the output
  // register, so the writer may refill it while that pixel waits downstream.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    row_eff = state;
    if (state == IDLE && full[rd_sel]) row_eff = ROW_A;
    load         = (~bus.VALID | bus.OUT_READY) & (row_eff != IDLE);
    out_line_end = load & (out_col == OUT_COL_LAST);
    release_bank = out_line_end & (row_eff == ROW_B);
    state_nxt    = row_eff;
    if (out_line_end) begin
      if (row_eff == ROW_A) state_nxt = ROW_B;
      else                  state_nxt = full[~rd_sel] ? ROW_A : IDLE;
    end
  end

  // Read FSM state register.
  always_ff @(posedge CLK) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Read side counters and bank pointer advance on every output load.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      out_col <= '0;
      out_row <= '0;
      rd_sel  <= 1'b0;
    end else if (load) begin
      out_col <= out_line_end ? '0 : out_col + 1'b1;
      if (out_line_end) out_row <= (out_row == OUT_ROW_LAST) ? '0 : out_row + 1'b1;
      if (release_bank) rd_sel <= ~rd_sel;
    end
  end

  // Output register: loads when empty or draining, holds everything while stalled.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      bus.OUT          <= '0;
      bus.VALID        <= 1'b0;
      bus.LAST_IN_LINE <= 1'b0;
      bus.LAST_PIX     <= 1'b0;
    end else if (load) begin
      bus.OUT          <= rdata[rd_sel];
      bus.VALID        <= 1'b1;
      bus.LAST_IN_LINE <= (out_col == OUT_COL_LAST);
      bus.LAST_PIX     <= (out_col == OUT_COL_LAST) && (out_row == OUT_ROW_LAST);
    end else if (bus.OUT_READY) begin
      bus.VALID        <= 1'b0;
      bus.LAST_IN_LINE <= 1'b0;
      bus.LAST_PIX     <= 1'b0;
    end
  end

`ifdef UNPOOL_PROTOCOL_CHECK_EN
  localparam logic [P_HCNT_W-2:0] IN_ROW_LAST = (P_HCNT_W-1)'(P_HEIGHT / 2 - 1);

  logic [P_HCNT_W-2:0] in_row;

  // Protocol check: track the pooled row and flag any mismatching end-of-line/frame marker.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      in_row <= '0;
      ERR    <= 1'b0;
    end else if (accept) begin
      if (in_line_end) in_row <= (in_row == IN_ROW_LAST) ? '0 : in_row + 1'b1;
      if ((bus.DIN_LAST_IN_LINE != (in_col == IN_COL_LAST)) ||
          (bus.DIN_LAST_PIX != ((in_col == IN_COL_LAST) && (in_row == IN_ROW_LAST))))
        ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_unpooling_core_2x2_cxy.sv
// Self-checking bench for unpooling_core_2x2_cxy: a 4x4 instance for the
// hand-computed frame and a default-size instance driven against a
// scoreboard of expected output pixels. UNPOOL_PROTOCOL_CHECK_EN also
// exercises the ERR output.
`timescale 1ns/1ps
module tb_unpooling_core_2x2_cxy;
  import unpool_pkg::*;

  localparam int DW = 24;
  localparam int W  = DEF_WIDTH;
  localparam int H  = DEF_HEIGHT;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          lil;
    logic          lp;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unpooling_core_2x2_cxy_if #(.DW(DW)) big_if ();
  unpooling_core_2x2_cxy_if #(.DW(DW)) small_if ();

`ifdef UNPOOL_PROTOCOL_CHECK_EN
  logic big_err;
  logic small_err;
`endif

  unpooling_core_2x2_cxy #(
    .P_WIDTH(W), .P_HEIGHT(H), .P_WCNT_W(4), .P_HCNT_W(4), .DW(DW)
  ) u_dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (big_if)
`ifdef UNPOOL_PROTOCOL_CHECK_EN
    ,
    .ERR  (big_err)
`endif
  );

  unpooling_core_2x2_cxy #(
    .P_WIDTH(4), .P_HEIGHT(4), .P_WCNT_W(2), .P_HCNT_W(2), .DW(DW)
  ) u_small (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (small_if)
`ifdef UNPOOL_PROTOCOL_CHECK_EN
    ,
    .ERR  (small_err)
`endif
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_xfer   = 0;
  int   small_n  = 0;
  int   m_col    = 0;
  int   m_irow   = 0;
  int   m_orow   = 0;
  bit   saw_stall  = 1'b0;
  bit   rand_ready = 1'b0;
  exp_t exp_q[$];
  exp_t small_got [16];
  logic [DW-1:0] m_line [IN_W];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int f, input int i);
    return DW'(f * 4096 + i * 5 + 1);
  endfunction

  // Reference model: collect a pooled line, then expand it into two output rows.
  task automatic model_accept(input logic [DW-1:0] d);
    m_line[m_col] = d;
    if (m_col == IN_W - 1) begin
      for (int rr = 0; rr < 2; rr++) begin
        for (int c = 0; c < W; c++)
          exp_q.push_back('{data: m_line[c / 2], lil: (c == W - 1),
                            lp: (c == W - 1) && (m_orow == H - 1)});
        m_orow = (m_orow == H - 1) ? 0 : m_orow + 1;
      end
      m_col  = 0;
      m_irow = (m_irow == IN_H - 1) ? 0 : m_irow + 1;
    end else begin
      m_col++;
    end
  endtask

  // Offer one pixel to the default-size instance and wait (bounded) for it to be taken.
  task automatic send_pix(input logic [DW-1:0] d, input bit lil_err);
    int n = 0;
    big_if.DIN              = d;
    big_if.DIN_VALID        = 1'b1;
    big_if.DIN_LAST_IN_LINE = (m_col == IN_W - 1) ^ lil_err;
    big_if.DIN_LAST_PIX     = (m_col == IN_W - 1) && (m_irow == IN_H - 1);
    while (!big_if.DIN_READY && n < 3000) begin
      saw_stall = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    if (big_if.DIN_READY) begin
      model_accept(d);
      @(posedge clk); #1;
    end else begin
      check("din_ready_timeout", 0, 1);
    end
    big_if.DIN_VALID = 1'b0;
  endtask

  task automatic send_frame(input int f);
    for (int i = 0; i < IN_W * IN_H; i++) send_pix(pix(f, i), 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || big_if.VALID) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Downstream ready: always 1, or a coin flip per cycle in the stall phase.
  initial begin
    big_if.OUT_READY = 1'b1;
    forever begin
      @(posedge clk); #1;
      big_if.OUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor for the default-size instance: stall stability and scoreboard.
  initial begin
    exp_t          e;
    logic [DW-1:0] prev_out;
    logic [1:0]    prev_flags;
    bit            prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid", big_if.VALID, 1);
        check("stall_out", big_if.OUT, prev_out);
        check("stall_flags", {big_if.LAST_IN_LINE, big_if.LAST_PIX}, prev_flags);
      end
      prev_stall = (big_if.VALID === 1'b1) && (big_if.OUT_READY === 1'b0);
      prev_out   = big_if.OUT;
      prev_flags = {big_if.LAST_IN_LINE, big_if.LAST_PIX};
      if (big_if.VALID === 1'b1 && big_if.OUT_READY === 1'b1) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", big_if.OUT, e.data);
          check("out_last_in_line", big_if.LAST_IN_LINE, e.lil);
          check("out_last_pix", big_if.LAST_PIX, e.lp);
        end
      end
    end
  end

  // Output capture for the 4x4 instance.
  initial begin
    forever begin
      @(negedge clk);
      if (small_if.VALID === 1'b1 && small_if.OUT_READY === 1'b1) begin
        if (small_n < 16)
          small_got[small_n] = '{data: small_if.OUT, lil: small_if.LAST_IN_LINE,
                                 lp: small_if.LAST_PIX};
        small_n++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    big_if.DIN_VALID          = 1'b0;
    big_if.DIN                = '0;
    big_if.DIN_LAST_IN_LINE   = 1'b0;
    big_if.DIN_LAST_PIX       = 1'b0;
    small_if.DIN_VALID        = 1'b0;
    small_if.DIN              = '0;
    small_if.DIN_LAST_IN_LINE = 1'b0;
    small_if.DIN_LAST_PIX     = 1'b0;
    small_if.OUT_READY        = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", big_if.VALID, 0);
    check("rst_last_in_line", big_if.LAST_IN_LINE, 0);
    check("rst_last_pix", big_if.LAST_PIX, 0);
    check("rst_out", big_if.OUT, 0);
    check("rst_din_ready", big_if.DIN_READY, 1);

    // 4x4 instance: pooled frame 1,2,3,4.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      small_if.DIN              = DW'(i + 1);
      small_if.DIN_VALID        = 1'b1;
      small_if.DIN_LAST_IN_LINE = (i % 2 == 1);
      small_if.DIN_LAST_PIX     = (i == 3);
      check("small_din_ready", small_if.DIN_READY, 1);
      @(posedge clk); #1;
    end
    small_if.DIN_VALID = 1'b0;
    repeat (30) @(negedge clk);
    check("small_count", small_n, 16);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        check("small_data", small_got[r * 4 + c].data, 1 + (r / 2) * 2 + c / 2);
        check("small_last_in_line", small_got[r * 4 + c].lil, (c == 3));
        check("small_last_pix", small_got[r * 4 + c].lp, (r == 3 && c == 3));
      end
    end

    // Latency of the first line, then the rest of the frame.
    @(posedge clk); #1;
    for (int i = 0; i < IN_W; i++) send_pix(pix(1, i), 1'b0);
    @(negedge clk);
    check("lat_t1_valid", big_if.VALID, 0);
    @(negedge clk);
    check("lat_t2_valid", big_if.VALID, 1);
    check("lat_t2_data", big_if.OUT, pix(1, 0));
    for (int i = IN_W; i < IN_W * IN_H; i++) send_pix(pix(1, i), 1'b0);
    wait_drain("drain_frame1");

    // Input held valid for two frames: writer must stall, output must be gap-free.
    saw_stall = 1'b0;
    fork
      begin
        send_frame(2);
        send_frame(3);
      end
      begin
        int gaps = 0;
        int waited = 0;
        while (big_if.VALID !== 1'b1 && waited < 200) begin
          @(negedge clk);
          waited++;
        end
        check("cont_first_valid", big_if.VALID, 1);
        for (int k = 0; k < 2 * W * H; k++) begin
          if (big_if.VALID !== 1'b1) gaps++;
          @(negedge clk);
        end
        check("cont_gaps", gaps, 0);
      end
    join
    check("cont_din_stalled", saw_stall, 1);
    wait_drain("drain_cont");

    // Random downstream backpressure.
    rand_ready = 1'b1;
    send_frame(4);
    wait_drain("drain_random");
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of ROW_B of the first line.
    base = n_xfer;
    for (int i = 0; i < 2 * IN_W; i++) send_pix(pix(5, i), 1'b0);
    n = 0;
    while (n_xfer < base + W + 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rowb_reached", (n_xfer >= base + W + 4), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    m_col  = 0;
    m_irow = 0;
    m_orow = 0;
    rst_n  = 1'b1;
    @(negedge clk);
    check("midrst_valid", big_if.VALID, 0);
    check("midrst_din_ready", big_if.DIN_READY, 1);
    send_frame(6);
    wait_drain("drain_after_reset");

`ifdef UNPOOL_PROTOCOL_CHECK_EN
    // Wrong end-of-line marker at column 3: ERR rises and sticks, data unaffected.
    check("err_clear", big_err, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_pix(pix(7, i), 1'b0);
    send_pix(pix(7, 3), 1'b1);
    @(negedge clk);
    check("err_set", big_err, 1);
    for (int i = 4; i < IN_W; i++) send_pix(pix(7, i), 1'b0);
    wait_drain("drain_err");
    check("err_sticky", big_err, 1);
    check("small_err_clear", small_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
